// File: rtl/program_loader.sv
// Byte-stream instruction loader: assembles high/low bytes into words and writes them to instruction memory.
// Optional checksum byte after the last word is enabled with `define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int MAX_WORDS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t                state;
    logic [BYTE_WIDTH-1:0] hi_byte;
    logic [ADDR_WIDTH:0]   word_len;
    logic [ADDR_WIDTH:0]   next_count;
    logic                  accept;
    logic                  bad_length;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] checksum;
`endif

    // Readiness depends on state only, so a byte is never taken outside a session.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_LEN, S_HI, S_LO: in_ready = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK:             in_ready = 1'b1;
`endif
            default:           in_ready = 1'b0;
        endcase
    end

    assign accept     = in_valid && in_ready;
    assign next_count = word_count + COUNT_ONE;
    assign bad_length = (in_data == '0) || (int'(in_data) > MAX_WORDS);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            hi_byte           <= '0;
            word_len          <= '0;
            mem_write_enable  <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            cpu_hold          <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
            word_count        <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum          <= '0;
`endif
        end else begin
            mem_write_enable <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_LEN;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        word_count <= '0;
                        cpu_hold   <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        checksum   <= '0;
`endif
                    end
                end
                S_LEN: begin
                    if (accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        checksum <= in_data;
`endif
                        if (bad_length) begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end else begin
                            word_len <= in_data[ADDR_WIDTH:0];
                            state    <= S_HI;
                        end
                    end
                end
                S_HI: begin
                    if (accept) begin
                        hi_byte <= in_data;
                        state   <= S_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        checksum <= checksum + in_data;
`endif
                    end
                end
                S_LO: begin
                    // The strobe and the counter step land together; the next HI byte may be taken in that same cycle.
                    if (accept) begin
                        mem_write_enable  <= 1'b1;
                        mem_write_address <= word_count[ADDR_WIDTH-1:0];
                        mem_write_data    <= {hi_byte, in_data};
                        word_count        <= next_count;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        checksum          <= checksum + in_data;
`endif
                        if (next_count == word_len) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state    <= S_CHK;
`else
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else begin
                            state <= S_HI;
                        end
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        if (in_data == checksum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: expected writes are queued as bytes are driven and
// compared against the write strobes the DUT actually produces.
module tb_program_loader;

    localparam int AW = 4;

    typedef logic [15:0] word_q_t[$];

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_write_enable;
    logic [AW-1:0] mem_write_address;
    logic [15:0]   mem_write_data;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    int checks = 0;
    int errors = 0;

    logic [AW+15:0] exp_q[$];
    logic [AW+15:0] obs_q[$];
    logic [AW+15:0] exp_w;
    logic [AW+15:0] obs_w;
    logic [15:0]    mem[2**AW];

    program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .BYTE_WIDTH(8)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .mem_write_enable  (mem_write_enable),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .cpu_hold          (cpu_hold),
        .done              (done),
        .error             (error),
        .word_count        (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side monitor: records every strobe cycle, so a strobe held two cycles shows up as an extra write.
    always @(negedge clk) begin
        if (mem_write_enable === 1'b1) begin
            obs_q.push_back({mem_write_address, mem_write_data});
            mem[mem_write_address] = mem_write_data;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  cycles   = 0;
        bit  accepted = 1'b0;
        while (!accepted && cycles < 50) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = b;
            end
            accepted = in_valid && in_ready;
            cycles++;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        if (!accepted) begin
            errors++;
            $display("[TB] FAIL byte_accept: byte %h not accepted within 50 cycles, in_ready=%b required 1", b, in_ready);
        end
    endtask

    task automatic drive_program(input logic [7:0] len, input word_q_t words, input bit gaps, input bit poke_start);
        logic [7:0] sum = len;
        send_byte(len, gaps);
        for (int i = 0; i < words.size(); i++) begin
            exp_q.push_back({AW'(i), words[i]});
            if (poke_start && i == 0) start = 1'b1;
            send_byte(words[i][15:8], gaps);
            send_byte(words[i][7:0], gaps);
            start = 1'b0;
            sum = sum + words[i][15:8] + words[i][7:0];
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(sum, gaps);
`else
        if (sum == 8'h00) exp_q = exp_q;
`endif
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b required 0", in_ready); end
        checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b required 0", mem_write_enable); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("[TB] FAIL reset_hold: got %b required 0", cpu_hold); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: done=%b error=%b required 0 0", done, error); end
        checks++; if (word_count !== '0 || mem_write_address !== '0 || mem_write_data !== '0) begin
            errors++; $display("[TB] FAIL reset_outputs: count=%0d addr=%h data=%h required 0 0 0", word_count, mem_write_address, mem_write_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic(input bit gaps, input string name);
        word_q_t w = '{16'h1234, 16'hABCD};
        obs_q.delete(); exp_q.delete();
        pulse_start();
        #1;
        checks++; if (cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL %s_session_open: hold=%b ready=%b required 1 1", name, cpu_hold, in_ready);
        end
        drive_program(8'h02, w, gaps, 1'b0);
        wait_cycles(3);
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL %s_write: missing, required %h", name, exp_w); end
            else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin errors++; $display("[TB] FAIL %s_write: got %h required %h", name, obs_w, exp_w); end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL %s_extra_writes: got %0d required 0", name, obs_q.size()); end
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("[TB] FAIL %s_done: done=%b error=%b required 1 0", name, done, error); end
        checks++; if (word_count !== 5'd2) begin errors++; $display("[TB] FAIL %s_count: got %0d required 2", name, word_count); end
        checks++; if (cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL %s_release: hold=%b ready=%b required 0 0", name, cpu_hold, in_ready);
        end
    endtask

    task automatic test_bad_length(input logic [7:0] len);
        obs_q.delete();
        pulse_start();
        #1;
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL badlen_%h_clear: error=%b required 0", len, error); end
        send_byte(len, 1'b0);
        wait_cycles(3);
        checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL badlen_%h_flags: error=%b done=%b required 1 0", len, error, done); end
        checks++; if (cpu_hold !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL badlen_%h_hold: hold=%b ready=%b required 1 0", len, cpu_hold, in_ready);
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL badlen_%h_writes: got %0d required 0", len, obs_q.size()); end
    endtask

    task automatic test_max_length();
        word_q_t w;
        for (int i = 0; i < 2**AW; i++) w.push_back(16'($urandom));
        obs_q.delete(); exp_q.delete();
        pulse_start();
        drive_program(8'(2**AW), w, 1'b0, 1'b0);
        wait_cycles(3);
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL max_write: missing, required %h", exp_w); end
            else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin errors++; $display("[TB] FAIL max_write: got %h required %h", obs_w, exp_w); end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL max_extra_writes: got %0d required 0", obs_q.size()); end
        checks++; if (word_count !== 5'd16 || done !== 1'b1) begin
            errors++; $display("[TB] FAIL max_count: count=%0d done=%b required 16 1", word_count, done);
        end
    endtask

    task automatic test_back_to_back();
        word_q_t w = '{16'h0F0F, 16'h5A5A, 16'hC3C3};
        obs_q.delete(); exp_q.delete();
        pulse_start();
        drive_program(8'h03, w, 1'b0, 1'b1);
        wait_cycles(3);
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL b2b_write: missing, required %h", exp_w); end
            else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin errors++; $display("[TB] FAIL b2b_write: got %h required %h", obs_w, exp_w); end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_extra_writes: got %0d required 0", obs_q.size()); end
        checks++; if (word_count !== 5'd3 || done !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_count: count=%0d done=%b required 3 1", word_count, done);
        end
    endtask

    task automatic test_reset_mid();
        obs_q.delete();
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'hAB, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_idle: ready=%b hold=%b required 0 0", in_ready, cpu_hold);
        end
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hCD;
        wait_cycles(4);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ready: got %b required 0", in_ready); end
        in_valid = 1'b0;
        wait_cycles(2);
        checks++; if (obs_q.size() != 1) begin errors++; $display("[TB] FAIL midreset_write_count: got %0d required 1", obs_q.size()); end
        checks++; if (mem[0] !== 16'h1234) begin errors++; $display("[TB] FAIL midreset_addr0: got %h required 1234", mem[0]); end
        checks++; if (mem[1] !== 16'h5A5A) begin errors++; $display("[TB] FAIL midreset_addr1: got %h required 5a5a", mem[1]); end
        checks++; if (word_count !== '0 || done !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_state: count=%0d done=%b required 0 0", word_count, done);
        end
    endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    task automatic test_checksum(input logic [7:0] cksum, input bit good);
        obs_q.delete();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(cksum, 1'b0);
        wait_cycles(3);
        checks++; if (obs_q.size() != 1 || mem[0] !== 16'h0005) begin
            errors++; $display("[TB] FAIL cksum_%h_write: writes=%0d addr0=%h required 1 0005", cksum, obs_q.size(), mem[0]);
        end
        checks++; if (done !== good || error !== !good) begin
            errors++; $display("[TB] FAIL cksum_%h_flags: done=%b error=%b required %b %b", cksum, done, error, good, !good);
        end
        checks++; if (cpu_hold !== !good) begin errors++; $display("[TB] FAIL cksum_%h_hold: got %b required %b", cksum, cpu_hold, !good); end
    endtask
`endif

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        test_reset();
        test_basic(1'b0, "basic");
        test_basic(1'b1, "random_valid");
        test_bad_length(8'h00);
        test_bad_length(8'h11);
        test_max_length();
        test_back_to_back();
        test_reset_mid();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        test_checksum(8'h07, 1'b0);
        test_checksum(8'h06, 1'b1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1, "[TB] timeout");
    end

endmodule
